// File: rtl/mem_2_out_reader.sv
// Reads a block of bytes from BRAM port B and streams them out one at a time
// with valid/ready handshaking. Optional running byte sum under READER_CHECKSUM_EN.
module mem_2_out_reader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_PRESENT, S_DONE} state_t;

    localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] REM_ONE   = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [1:0]          wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                hs;

    assign hs = (state_q == S_PRESENT) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (count == '0) ? S_DONE : S_READ;
            S_READ:    state_d = S_WAIT;
            S_WAIT:    if (wait_cnt_q == WAIT_LAST) state_d = S_PRESENT;
            S_PRESENT: if (out_ready) state_d = (remaining_q == REM_ONE) ? S_DONE : S_READ;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enb  = (state_q == S_READ);
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath: the final WAIT edge captures doutb, the handshake edge advances
    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start && count != '0) begin
                    ptr_d       = base_addr;
                    remaining_d = count;
                end
            end
            S_READ: wait_cnt_d = '0;
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    out_data_d  = doutb;
                    out_valid_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - REM_ONE;
                    ptr_d       = ptr_q + REM_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign web       = 1'b0;
    assign addrb     = ptr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) begin
            checksum_d = '0;
        end else if (hs) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_2_out_reader.sv
// Scoreboard bench for mem_2_out_reader: expected addresses and bytes are queued
// by the stimulus and consumed by a monitor that watches enb and handshakes.
module tb_mem_2_out_reader;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] count = '0;
    logic          enb, web, out_valid, busy, done;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb = '0;
    logic [DW-1:0] out_data, checksum;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] exp_addr[$];
    int            hs_cyc[$];

    mem_2_out_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .enb(enb), .web(web), .addrb(addrb), .doutb(doutb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM port-B model with one cycle of read latency
    always @(posedge clk) if (enb) doutb <= mem[addrb];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (enb) begin
                if (exp_addr.size() == 0) fail_now("unexpected_enb");
                else chk("addrb", addrb, exp_addr.pop_front());
                chk("web", web, 0);
            end
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_data.size() == 0) fail_now("unexpected_byte");
                else chk("out_data", out_data, exp_data.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [AW-1:0] c, output int s0);
        start = 1'b1;
        base_addr = b;
        count = c;
        s0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        if (busy) fail_now("timeout_idle");
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!out_valid && n < lim) begin
            tick();
            n++;
        end
        if (!out_valid) fail_now("timeout_valid");
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
        if (!done) fail_now("timeout_done");
    endtask

    task automatic chk_sum(input string nm, input logic [DW-1:0] on_val);
`ifdef READER_CHECKSUM_EN
        chk(nm, checksum, on_val);
`else
        chk(nm, checksum, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int dc;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[13'h010] = 8'h11; mem[13'h011] = 8'h22; mem[13'h012] = 8'h33;
        mem[13'h1FFF] = 8'hA5; mem[13'h000] = 8'h5A;
        mem[13'h020] = 8'h77; mem[13'h021] = 8'h90;
        mem[13'h030] = 8'h3C; mem[13'h031] = 8'hC3;
        mem[13'h022] = 8'h99;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enb", enb, 0);
        chk("rst_web", web, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        rst = 1'b1;
        tick();

        // Three bytes, ready held high: one byte every 3 cycles
        out_ready = 1'b1;
        exp_addr.push_back(13'h010); exp_addr.push_back(13'h011); exp_addr.push_back(13'h012);
        exp_data.push_back(8'h11); exp_data.push_back(8'h22); exp_data.push_back(8'h33);
        hs_cyc.delete();
        go(13'h010, 13'd3, s0);
        wait_idle(50);
        chk("hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("hs0_cycle", hs_cyc[0], s0 + 3);
            chk("hs1_cycle", hs_cyc[1], s0 + 6);
            chk("hs2_cycle", hs_cyc[2], s0 + 9);
        end
        chk("done_cycle", done_cyc, s0 + 10);
        chk_sum("sum_3byte", 8'h66);

        // Zero-length block
        dc = done_cnt;
        go(13'h040, 13'd0, s0);
        wait_idle(10);
        chk("zero_done_cnt", done_cnt, dc + 1);
        chk("zero_done_cycle", done_cyc, s0 + 1);
        chk("zero_sum", checksum, 0);

        // Address wrap
        exp_addr.push_back(13'h1FFF); exp_addr.push_back(13'h0000);
        exp_data.push_back(8'hA5); exp_data.push_back(8'h5A);
        go(13'h1FFF, 13'd2, s0);
        wait_idle(50);
        chk("wrap_addr_q", exp_addr.size(), 0);
        chk("wrap_data_q", exp_data.size(), 0);
        chk_sum("wrap_sum", 8'hFF);

        // Backpressure in PRESENT
        out_ready = 1'b0;
        exp_addr.push_back(13'h020); exp_addr.push_back(13'h021);
        exp_data.push_back(8'h77); exp_data.push_back(8'h90);
        go(13'h020, 13'd2, s0);
        wait_valid(20);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h77);
            chk("bp_enb", enb, 0);
        end
        chk("bp_addr_pending", exp_addr.size(), 1);
        out_ready = 1'b1;
        wait_idle(50);
        chk("bp_data_q", exp_data.size(), 0);
        chk_sum("bp_sum", 8'h07);

        // start while busy and in the DONE cycle is ignored
        exp_addr.push_back(13'h030); exp_addr.push_back(13'h031);
        exp_data.push_back(8'h3C); exp_data.push_back(8'hC3);
        go(13'h030, 13'd2, s0);
        tick();
        start = 1'b1; base_addr = 13'h100; count = 13'd5;
        tick();
        start = 1'b0;
        wait_done(50);
        start = 1'b1; base_addr = 13'h200; count = 13'd1;
        tick();
        start = 1'b0;
        chk("busy_after_done_start", busy, 0);
        chk("busy_addr_q", exp_addr.size(), 0);
        chk("busy_data_q", exp_data.size(), 0);
        chk_sum("busy_sum", 8'hFF);

        // Asynchronous reset mid-PRESENT
        out_ready = 1'b0;
        exp_addr.push_back(13'h010); exp_addr.push_back(13'h011); exp_addr.push_back(13'h012);
        go(13'h010, 13'd3, s0);
        wait_valid(20);
        dc = done_cnt;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_enb", enb, 0);
        chk("arst_addrb", addrb, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_checksum", checksum, 0);
        exp_addr.delete();
        exp_data.delete();
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        exp_addr.push_back(13'h022);
        exp_data.push_back(8'h99);
        go(13'h022, 13'd1, s0);
        chk("post_rst_busy", busy, 1);
        wait_idle(20);
        chk("post_rst_done_cnt", done_cnt, dc + 1);
        chk_sum("post_rst_sum", 8'h99);

        chk("final_addr_q", exp_addr.size(), 0);
        chk("final_data_q", exp_data.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_2_out_reader.md
MEM_2_OUT_READER -- requirements
Module: mem_2_out_reader

Interface
REQ-001 Parameter ADDR_W, default 13: BRAM address width.
REQ-002 Parameter DATA_W, default 8: BRAM data and stream width.
REQ-003 Parameter RD_LAT, default 1, legal 1..3: BRAM read latency in cycles.
REQ-004 clk  in  1  single clock; all state on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to read a block.
REQ-007 base_addr  in  ADDR_W  first address of the block, sampled with start.
REQ-008 count  in  ADDR_W  number of bytes to read, sampled with start.
REQ-009 enb  out  1  BRAM port-B enable.
REQ-010 web  out  1  BRAM port-B write enable, constant 0.
REQ-011 addrb  out  ADDR_W  BRAM port-B address.
REQ-012 doutb  in  DATA_W  BRAM port-B read data.
REQ-013 out_data  out  DATA_W  stream byte.
REQ-014 out_valid  out  1  stream byte valid.
REQ-015 out_ready  in  1  downstream accepts the byte.
REQ-016 busy  out  1  block transfer in progress.
REQ-017 done  out  1  one-cycle pulse marking the end of a block.
REQ-018 checksum  out  DATA_W  running byte sum (see Configuration).

Function
REQ-019 FSM states: IDLE, READ, WAIT, PRESENT, DONE.
REQ-020 IDLE: start=1 with count!=0 -> latch ptr=base_addr, remaining=count -> READ.
REQ-021 IDLE: start=1 with count=0 -> DONE; no BRAM access.
REQ-022 READ, one cycle: enb=1, addrb=ptr -> WAIT. enb is 0 in every other state.
REQ-023 WAIT lasts exactly RD_LAT cycles; the last edge in WAIT registers doutb into out_data, sets out_valid=1, and moves to PRESENT.
REQ-024 PRESENT: out_valid and out_data stay stable until an edge where out_ready=1.
REQ-025 Handshake edge: out_valid clears, remaining decrements, ptr increments.
REQ-026 After the handshake: remaining=0 -> DONE; otherwise -> READ.
REQ-027 ptr wraps from 2^ADDR_W-1 to 0; no error is flagged.
REQ-028 DONE, one cycle: done=1 -> IDLE.
REQ-029 busy=1 in every state except IDLE.
REQ-030 start is ignored outside IDLE, including in the DONE cycle.
REQ-031 Latency: out_valid rises RD_LAT+1 edges after the edge that samples start.
REQ-032 With out_ready held high, throughput is one byte per RD_LAT+2 cycles.
REQ-033 out_ready has no effect while out_valid=0.

Reset
REQ-034 rst=0 asynchronously forces state=IDLE.
REQ-035 rst=0 forces enb=0, web=0, addrb=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0, ptr=0, remaining=0.
REQ-036 Reset during a transfer abandons it; no done pulse is issued.
REQ-037 After rst rises, the first start is accepted on the next edge.

Configuration
REQ-038 Macro READER_CHECKSUM_EN.
REQ-039 With the macro defined: checksum clears to 0 on an accepted start, then adds out_data modulo 2^DATA_W on each handshake edge; the value holds after DONE until the next accepted start.
REQ-040 Without the macro: checksum is tied to 0 and no accumulator is synthesized.

Verification
REQ-041 Reset to 0 mid-PRESENT -> all outputs 0 within the same cycle, state IDLE, no done pulse.
REQ-042 RD_LAT=1, base_addr=0x010, count=3, memory 0x11,0x22,0x33, out_ready=1 -> bytes 0x11,0x22,0x33 every 3 cycles; done one cycle after the third handshake; checksum=0x66 (macro on) or 0 (macro off).
REQ-043 count=0 start -> done pulses the next cycle; enb never asserts.
REQ-044 base_addr=0x1FFF, count=2 -> addrb sequence 0x1FFF, 0x0000.
REQ-045 out_ready held 0 for 5 cycles in PRESENT -> out_data stable, no extra enb; next byte read only after the handshake.
REQ-046 start pulsed while busy -> ignored; the transfer in flight completes unchanged.
